// File: rtl/gpsclock_tb_sched.sv
// gpsclock_tb_sched: PPS-driven bench snapshot sequencer and bus arbiter; define GPSCLOCK_TB_SCHED_TIMEOUT_EN to enable the bench-bus timeout
module gpsclock_tb_sched #(
  parameter int DW     = 32,
  parameter int LGFIFO = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_lcl_pps,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [1:0]    i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic [DW-1:0] o_wb_data,
  output logic          o_tb_cyc_stb,
  output logic          o_tb_we,
  output logic [2:0]    o_tb_addr,
  output logic [DW-1:0] o_tb_data,
  input  logic          i_tb_ack,
  input  logic [DW-1:0] i_tb_data,
  output logic          o_int
);
  localparam int DEPTH = 1 << LGFIFO;
  typedef enum logic [2:0] {RELEASE, IDLE, CAPTURE, JUMP, MAXW} state_t;
  state_t state_q, state_d;
  logic [2:0] cap_q, cap_d, tb_addr_q, tb_addr_d, nxt_addr;
  logic en_q, en_d, arm_q, arm_d, missed_q, missed_d, tmo_q, tmo_d, drop_q, drop_d;
  logic maxp_q, maxp_d, reissue_q, reissue_d, cyc_q, cyc_d, tb_we_q, tb_we_d, nxt_we;
  logic ack_q, int_q, int_d, want, done, req, wr, wr0, wr2, push, pop, tmo_hit;
  logic [DW-1:0] jump_q, jump_d, max_q, max_d, tb_data_q, tb_data_d, nxt_data, rdata_q, rdata_d, status;
  logic [LGFIFO-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LGFIFO:0] fill_q, fill_d, free;
  logic [DW-1:0] mem_q [DEPTH];
  assign o_wb_ack     = ack_q;
  assign o_wb_stall   = 1'b0;
  assign o_wb_data    = rdata_q;
  assign o_tb_cyc_stb = cyc_q;
  assign o_tb_we      = tb_we_q;
  assign o_tb_addr    = tb_addr_q;
  assign o_tb_data    = tb_data_q;
  assign o_int        = int_q;
`ifdef GPSCLOCK_TB_SCHED_TIMEOUT_EN
  logic [3:0] tcnt_q, tcnt_d;
  // Count consecutive unacknowledged request cycles; the 16th abandons the request
  always_comb begin
    tcnt_d  = (cyc_q && !i_tb_ack) ? tcnt_q + 4'd1 : 4'd0;
    tmo_hit = cyc_q && !i_tb_ack && tcnt_q == 4'd15;
  end
  // Timeout counter register
  always_ff @(posedge i_clk) tcnt_q <= i_reset ? 4'd0 : tcnt_d;
`else
  assign tmo_hit = 1'b0;
`endif
  // Slave decode, FIFO bookkeeping, sequencer next state and master request
  always_comb begin
    req       = i_wb_cyc && i_wb_stb;
    wr        = req && i_wb_we;
    wr0       = wr && i_wb_addr == 2'd0;
    wr2       = wr && i_wb_addr == 2'd2;
    done      = cyc_q && i_tb_ack;
    free      = (LGFIFO+1)'(DEPTH) - fill_q;
    pop       = req && !i_wb_we && i_wb_addr == 2'd3 && fill_q != '0;
    push      = done && state_q == CAPTURE;
    fill_d    = fill_q + (LGFIFO+1)'(push) - (LGFIFO+1)'(pop);
    wp_d      = wp_q + LGFIFO'(push);
    rp_d      = rp_q + LGFIFO'(pop);
    int_d     = fill_d >= (LGFIFO+1)'(7);
    status    = DW'({fill_q, 3'b000, missed_q, tmo_q, drop_q, state_q != IDLE, en_q});
    rdata_d   = (!req || i_wb_we) ? '0 : i_wb_addr == 2'd0 ? status : i_wb_addr == 2'd1 ? jump_q :
                i_wb_addr == 2'd2 ? max_q : pop ? mem_q[rp_q] : '0;
    en_d      = wr0 ? i_wb_data[0] : en_q;
    arm_d     = wr0 ? i_wb_data[1] : arm_q;
    {missed_d, tmo_d, drop_d} = (wr0 && i_wb_data[2]) ? 3'b000 : {missed_q, tmo_q, drop_q};
    missed_d  = missed_d || (i_lcl_pps && state_q != IDLE);
    jump_d    = (wr && i_wb_addr == 2'd1) ? i_wb_data : jump_q;
    max_d     = wr2 ? i_wb_data : max_q;
    maxp_d    = maxp_q || wr2;
    reissue_d = reissue_q || (wr2 && state_q == MAXW);
    state_d   = state_q;
    cap_d     = cap_q;
    want      = 1'b0;
    nxt_we    = 1'b0;
    nxt_addr  = 3'd0;
    nxt_data  = '0;
    case (state_q)
      RELEASE: begin
        want     = 1'b1;
        nxt_addr = 3'd7;
        if (done) state_d = IDLE;
      end
      IDLE: begin
        if (en_q && i_lcl_pps) begin
          if (free >= (LGFIFO+1)'(7)) begin
            state_d = CAPTURE;
            cap_d   = 3'd1;
          end else drop_d = 1'b1;
        end else if (maxp_q) state_d = MAXW;
      end
      CAPTURE: begin
        want     = 1'b1;
        nxt_addr = cap_q;
        if (done) begin
          cap_d = cap_q + 3'd1;
          if (cap_q == 3'd7) state_d = arm_q ? JUMP : IDLE;
        end
      end
      JUMP: begin
        want     = 1'b1;
        nxt_we   = 1'b1;
        nxt_addr = 3'd1;
        nxt_data = jump_q;
        if (done) begin
          arm_d   = 1'b0;
          state_d = IDLE;
        end
      end
      MAXW: begin
        want     = 1'b1;
        nxt_we   = 1'b1;
        nxt_data = max_q;
        if (done) begin
          maxp_d    = reissue_d;
          reissue_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = RELEASE;
    endcase
    if (tmo_hit) begin
      state_d = RELEASE;
      tmo_d   = 1'b1;
    end
    cyc_d     = !tmo_hit && (cyc_q ? !i_tb_ack : want);
    tb_addr_d = !cyc_d ? 3'd0 : cyc_q ? tb_addr_q : nxt_addr;
    tb_we_d   = cyc_d && (cyc_q ? tb_we_q : nxt_we);
    tb_data_d = !cyc_d ? '0 : cyc_q ? tb_data_q : nxt_data;
  end
  // State registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= RELEASE;
      cap_q     <= 3'd0;
      en_q      <= 1'b0;
      arm_q     <= 1'b0;
      missed_q  <= 1'b0;
      tmo_q     <= 1'b0;
      drop_q    <= 1'b0;
      maxp_q    <= 1'b0;
      reissue_q <= 1'b0;
      jump_q    <= '0;
      max_q     <= '0;
      cyc_q     <= 1'b0;
      tb_we_q   <= 1'b0;
      tb_addr_q <= 3'd0;
      tb_data_q <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      int_q     <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      en_q      <= en_d;
      arm_q     <= arm_d;
      missed_q  <= missed_d;
      tmo_q     <= tmo_d;
      drop_q    <= drop_d;
      maxp_q    <= maxp_d;
      reissue_q <= reissue_d;
      jump_q    <= jump_d;
      max_q     <= max_d;
      cyc_q     <= cyc_d;
      tb_we_q   <= tb_we_d;
      tb_addr_q <= tb_addr_d;
      tb_data_q <= tb_data_d;
      ack_q     <= req;
      rdata_q   <= rdata_d;
      int_q     <= int_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      fill_q    <= fill_d;
    end
  end
  // Snapshot FIFO storage
  always_ff @(posedge i_clk) if (push) mem_q[wp_q] <= i_tb_data;
endmodule
